hello_checker: RTL and testbench
================================

# hello_checker

Receive-side checker for the 8-bit letter stream produced by the message generator. It consumes one letter per valid beat and tracks position within the fixed message "Hello, World!" (13 bytes). It pulses `match` when a complete message arrives intact and `error` on a mismatch mid-message. It sits at the generator's output, or any downstream byte path, and gives a self-checking pass/fail and a message count.

## Interface
- `MSG_LEN`, default 13: message length in bytes; must equal the package message constant length.
- `CNT_W`, default 8: width of the saturating message counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `letter`  in  8  incoming character byte.
- `valid`  in  1  `letter` is sampled only when high.
- `match`  out  1  one-cycle pulse: full message received correctly.
- `error`  out  1  one-cycle pulse: wrong byte while a message was in progress.
- `busy`  out  1  high while a message is in progress (index > 0).
- `index`  out  4  number of bytes matched so far in the current message (0..MSG_LEN-1).
- `msg_count`  out  CNT_W  count of correct messages, saturating at all-ones.

## Operation
- Expected bytes by index: 0x48 0x65 0x6C 0x6C 0x6F 0x2C 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21.
- FSM states:
  - IDLE: index = 0.
  - RECV: 0 < index < MSG_LEN.
- IDLE, valid byte:
  - Byte == 0x48 ('H'): go to RECV, index = 1.
  - Any other byte: ignored, no `error`, stay IDLE.
- RECV, valid byte == expected[index], index < MSG_LEN-1: index increments.
- RECV, valid byte == expected[MSG_LEN-1] at index MSG_LEN-1:
  - `match` pulses.
  - `msg_count` increments unless it is all-ones.
  - Go to IDLE, index = 0.
- RECV, valid byte != expected[index]: `error` pulses, then resync:
  - Byte == 0x48: index = 1, stay RECV.
  - Otherwise: IDLE, index = 0.
  - No partial-prefix backtracking beyond this single-'H' restart.
- `valid` low: all state holds, and `match`/`error` are low.
- `match` and `error` are never high in the same cycle.
- `msg_count` saturates: once all-ones, further matches still pulse `match` but the count holds.

## Timing
- All outputs registered.
- Reset values: `match` = 0, `error` = 0, `busy` = 0, `index` = 0, `msg_count` = 0, state = IDLE.
- Latency: the byte sampled at edge N is reflected in `index`/`busy`/`match`/`error` immediately after edge N, i.e. visible for cycle N+1.
- `match`/`error` are high for exactly one cycle per triggering byte.
- Back-to-back messages with no gap are supported: the 0x48 after a final '!' starts a new message on the next beat.
- Reset asserted mid-message:
  - Next edge returns all outputs to reset values.
  - No `error` is generated for the abandoned message.
  - Reset dominates `valid` in the same cycle.
- Throughput: one byte per cycle; no backpressure (there is no ready signal).

## Structure
- Shared package `hello_pkg` holds:
  - `MSG_LEN`.
  - Message byte constant array, shared with the generator so both ends agree.
  - State enum {IDLE, RECV}.
- One natural sub-module, `hello_rom`: combinational index → expected byte lookup from the package constant. The checker FSM and counter stay in `hello_checker`.
- Target size: 120–200 lines of RTL.

## Test plan
- Clean message: 13 consecutive valid beats "Hello, World!" after reset → `index` steps 1..12, `match` high one cycle after the 0x21 edge, `msg_count` = 1, `error` never high.
- Gapped input: same message with `valid` low for 3 cycles after 'o' (index 5) → `index` holds at 5 during the gap, `match` after '!', `msg_count` = 1.
- Mismatch: "Hellx" (0x78 at index 4) → `error` one-cycle pulse, `index` = 0, `busy` = 0. Follow with "H" → `index` = 1.
- Restart on 'H': "HelH" then "ello, World!" → `error` on the second 'H', `index` = 1, then `match`, `msg_count` = 1.
- Reset mid-message: 6 bytes in, `reset` high one cycle → `index` = 0, `msg_count` = 0, `busy` = 0, no `error`. The next full message produces a `match`.
- Saturation and idle noise: CNT_W = 2, five correct messages back-to-back, interleaved with non-'H' bytes while IDLE → `match` pulses 5 times, `msg_count` stops at 3, no `error` from idle noise.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared definitions for the "Hello, World!" generator and checker pair.
// Both ends take the message bytes from here so they always agree.
package hello_pkg;

  localparam int MSG_LEN = 13;

  // Message bytes in transmission order; element 0 is sent first.
  localparam logic [0:MSG_LEN-1][7:0] MSG_BYTES = {
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21
  };

  // The first byte of the message; also the resync byte after a mismatch.
  localparam logic [7:0] START_BYTE = 8'h48;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

endpackage

// File: rtl/hello_rom.sv
// Combinational lookup of the expected message byte at a given position.
// Positions past the end of the message return zero.
module hello_rom
  import hello_pkg::*;
(
  input  logic [3:0] index,
  output logic [7:0] expected
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  // Select the message byte for the current position.
  always_comb begin
    expected = 8'h00;
    if (index <= LAST_IDX) begin
      expected = MSG_BYTES[index];
    end
  end

endmodule

// File: rtl/hello_checker.sv
// Receive-side checker for the "Hello, World!" letter stream.
// Tracks position within the message, pulses match on a complete intact
// message and error on a wrong byte mid-message, and keeps a saturating
// count of good messages. A wrong byte that is itself 'H' restarts the
// message at position 1; no other partial-prefix recovery is attempted.
module hello_checker
  import hello_pkg::*;
#(
  parameter int MSG_LEN = hello_pkg::MSG_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       letter,
  input  logic             valid,
  output logic             match,
  output logic             error,
  output logic             busy,
  output logic [3:0]       index,
  output logic [CNT_W-1:0] msg_count
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       index_next;
  logic             match_next;
  logic             error_next;
  logic [CNT_W-1:0] count_next;
  logic [7:0]       expected;

  hello_rom u_rom (
    .index    (index),
    .expected (expected)
  );

  // busy is a direct decode of the single-bit state register.
  assign busy = (state == RECV);

  // Register state, position, pulses and the message counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      match     <= 1'b0;
      error     <= 1'b0;
      msg_count <= '0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      match     <= match_next;
      error     <= error_next;
      msg_count <= count_next;
    end
  end

  // Next-state logic: advance on a correct byte, resync on a wrong one.
  always_comb begin
    state_next = state;
    index_next = index;
    match_next = 1'b0;
    error_next = 1'b0;
    count_next = msg_count;

    if (valid) begin
      case (state)
        IDLE: begin
          if (letter == START_BYTE) begin
            state_next = RECV;
            index_next = 4'd1;
          end
        end
        RECV: begin
          if (letter == expected) begin
            if (index == LAST_IDX) begin
              match_next = 1'b1;
              count_next = (&msg_count) ? msg_count : msg_count + 1'b1;
              state_next = IDLE;
              index_next = 4'd0;
            end else begin
              index_next = index + 4'd1;
            end
          end else begin
            error_next = 1'b1;
            if (letter == START_BYTE) begin
              state_next = RECV;
              index_next = 4'd1;
            end else begin
              state_next = IDLE;
              index_next = 4'd0;
            end
          end
        end
        default: begin
          state_next = IDLE;
          index_next = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hello_checker.sv
// Scoreboard bench for hello_checker with a 2-bit message counter so that
// saturation is reachable. The driver pushes the hand-computed expected
// outputs for every cycle it drives; the monitor pops one entry after each
// rising edge and compares it against the DUT outputs.
module tb_hello_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] letter;
  logic       valid;
  logic       match;
  logic       error;
  logic       busy;
  logic [3:0] index;
  logic [1:0] msg_count;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string      name;
    logic       m;
    logic       e;
    logic       b;
    logic [3:0] idx;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] msg [13];

  always #5 clk = ~clk;

  hello_checker #(
    .MSG_LEN (13),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .letter    (letter),
    .valid     (valid),
    .match     (match),
    .error     (error),
    .busy      (busy),
    .index     (index),
    .msg_count (msg_count)
  );

  // Compare one popped expectation against the current DUT outputs.
  task automatic checkOutput(input exp_t e);
    checks++;
    if ({match, error, busy, index, msg_count} !== {e.m, e.e, e.b, e.idx, e.cnt}) begin
      fails++;
      $display("[TB] FAIL %s: got match=%b error=%b busy=%b index=%0d count=%0d, want match=%b error=%b busy=%b index=%0d count=%0d",
               e.name, match, error, busy, index, msg_count,
               e.m, e.e, e.b, e.idx, e.cnt);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] l,
                               input logic [3:0] eidx, input logic em, input logic ee,
                               input logic [1:0] ecnt, input string tag);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    valid  = v;
    letter = l;
    e = '{name: tag, m: em, e: ee, b: (eidx != 4'd0), idx: eidx, cnt: ecnt};
    exp_q.push_back(e);
  endtask

  // Send message bytes first..last; the final '!' completes the message.
  task automatic sendRange(input int first, input int last,
                           input logic [1:0] cnt_before, input logic [1:0] cnt_after,
                           input string tag);
    for (int i = first; i <= last; i++) begin
      if (i == 12)
        applyStimulus(1'b0, 1'b1, msg[i], 4'd0, 1'b1, 1'b0, cnt_after, tag);
      else
        applyStimulus(1'b0, 1'b1, msg[i], 4'(i + 1), 1'b0, 1'b0, cnt_before, tag);
    end
  endtask

  // Pop and compare one expectation shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
            8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    reset  = 1'b1;
    valid  = 1'b0;
    letter = 8'h00;

    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset");
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset");

    // Clean message.
    sendRange(0, 12, 2'd0, 2'd1, "clean");
    applyStimulus(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd1, "clean_after");
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset2");

    // Gapped input: valid low for 3 cycles after 'o'; an 'H' on the bus is ignored.
    sendRange(0, 4, 2'd0, 2'd0, "gap_pre");
    applyStimulus(1'b0, 1'b0, 8'h48, 4'd5, 1'b0, 1'b0, 2'd0, "gap_hold");
    applyStimulus(1'b0, 1'b0, 8'h78, 4'd5, 1'b0, 1'b0, 2'd0, "gap_hold");
    applyStimulus(1'b0, 1'b0, 8'h2C, 4'd5, 1'b0, 1'b0, 2'd0, "gap_hold");
    sendRange(5, 12, 2'd0, 2'd1, "gap_post");
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset3");

    // Mismatch "Hellx", then 'H' restarts.
    sendRange(0, 3, 2'd0, 2'd0, "mis_pre");
    applyStimulus(1'b0, 1'b1, 8'h78, 4'd0, 1'b0, 1'b1, 2'd0, "mis_x");
    applyStimulus(1'b0, 1'b1, 8'h48, 4'd1, 1'b0, 1'b0, 2'd0, "mis_h");
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset4");

    // Restart on 'H': "HelH" then "ello, World!".
    sendRange(0, 2, 2'd0, 2'd0, "rst_h_pre");
    applyStimulus(1'b0, 1'b1, 8'h48, 4'd1, 1'b0, 1'b1, 2'd0, "rst_h_err");
    sendRange(1, 12, 2'd0, 2'd1, "rst_h_post");

    // Wrong final byte at the last position.
    sendRange(0, 11, 2'd1, 2'd1, "last_pre");
    applyStimulus(1'b0, 1'b1, 8'h3F, 4'd0, 1'b0, 1'b1, 2'd1, "last_err");

    // Reset mid-message, with valid high on the reset cycle.
    sendRange(0, 5, 2'd1, 2'd1, "mid_pre");
    applyStimulus(1'b1, 1'b1, 8'h65, 4'd0, 1'b0, 1'b0, 2'd0, "mid_reset");
    sendRange(0, 12, 2'd0, 2'd1, "mid_post");

    // Saturation with idle noise.
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, "reset5");
    sendRange(0, 12, 2'd0, 2'd1, "sat1");
    applyStimulus(1'b0, 1'b1, 8'h78, 4'd0, 1'b0, 1'b0, 2'd1, "noise");
    applyStimulus(1'b0, 1'b1, 8'h21, 4'd0, 1'b0, 1'b0, 2'd1, "noise");
    applyStimulus(1'b0, 1'b1, 8'h65, 4'd0, 1'b0, 1'b0, 2'd1, "noise");
    sendRange(0, 12, 2'd1, 2'd2, "sat2");
    sendRange(0, 12, 2'd2, 2'd3, "sat3");
    applyStimulus(1'b0, 1'b1, 8'h6C, 4'd0, 1'b0, 1'b0, 2'd3, "noise");
    sendRange(0, 12, 2'd3, 2'd3, "sat4");
    sendRange(0, 12, 2'd3, 2'd3, "sat5");
    applyStimulus(1'b0, 1'b0, 8'h48, 4'd0, 1'b0, 1'b0, 2'd3, "sat_idle");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
